// File: rtl/lsu_bus_router.sv
// lsu_bus_router: registered base/mask address router from the LSU to N targets; optional o_err_count under ROUTER_ERR_CNT_EN
module lsu_bus_router #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h1002_0000, 32'h1001_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F800},
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [ADDR_W-1:0]             i_req_addr,
  input  logic                          i_req_wren,
  input  logic [DATA_W-1:0]             i_req_wdata,
  input  logic [DATA_W/8-1:0]           i_req_bmask,
  output logic [NUM_REGIONS-1:0]        o_slv_valid,
  output logic [ADDR_W-1:0]             o_slv_addr,
  output logic                          o_slv_wren,
  output logic [DATA_W-1:0]             o_slv_wdata,
  output logic [DATA_W/8-1:0]           o_slv_bmask,
  input  logic [NUM_REGIONS-1:0]        i_slv_ready,
  input  logic [NUM_REGIONS-1:0]        i_slv_rvalid,
  input  logic [NUM_REGIONS*DATA_W-1:0] i_slv_rdata,
  output logic                          o_rsp_valid,
  output logic [DATA_W-1:0]             o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic                          o_busy
`ifdef ROUTER_ERR_CNT_EN
  ,output logic [15:0]                  o_err_count
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW:0] TMO = (CW+1)'(TIMEOUT_CYC);
  state_t state, state_nx;
  logic [NUM_REGIONS-1:0] hit, sel;
  logic [ADDR_W-1:0] addr;
  logic wren, err, ready_sel, rvalid_sel, tmo;
  logic [DATA_W-1:0] wdata, rdata, rsel;
  logic [DATA_W/8-1:0] bmask;
  logic [CW-1:0] cnt;
  logic [CW:0] cnt_nx;
  // descending scan so the lowest matching region overrides higher ones
  always_comb begin
    hit = '0;
    rsel = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--)
      if ((i_req_addr & REGION_MASK[k*ADDR_W +: ADDR_W]) == REGION_BASE[k*ADDR_W +: ADDR_W])
        hit = NUM_REGIONS'(1) << k;
    for (int k = 0; k < NUM_REGIONS; k++)
      rsel = rsel | ({DATA_W{sel[k]}} & i_slv_rdata[k*DATA_W +: DATA_W]);
  end
  assign ready_sel = |(i_slv_ready & sel);
  assign rvalid_sel = |(i_slv_rvalid & sel);
  assign cnt_nx = {1'b0, cnt} + (CW+1)'(1);
  assign tmo = (TIMEOUT_CYC != 0) && (state == ISSUE || state == WAIT) && cnt_nx == TMO;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !i_req_valid ? IDLE : |hit ? ISSUE : RESP;
      ISSUE:   state_nx = tmo ? RESP : !ready_sel ? ISSUE : wren ? RESP : WAIT;
      WAIT:    state_nx = tmo || rvalid_sel ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      addr <= '0;
      wren <= 1'b0;
      wdata <= '0;
      bmask <= '0;
      sel <= '0;
      err <= 1'b0;
      rdata <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_req_valid) begin
        addr <= i_req_addr;
        wren <= i_req_wren;
        wdata <= i_req_wdata;
        bmask <= i_req_bmask;
        sel <= hit;
        err <= ~|hit;
        rdata <= '0;
        cnt <= '0;
      end
      if (state == ISSUE || state == WAIT) cnt <= &cnt ? cnt : cnt + CW'(1);
      if (tmo) err <= 1'b1;
      else if (state == WAIT && rvalid_sel) rdata <= rsel;
    end
  end
`ifdef ROUTER_ERR_CNT_EN
  logic [15:0] err_count;
  always_ff @(posedge i_clk) begin
    if (i_reset) err_count <= '0;
    else if (state == RESP && err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
  assign o_err_count = err_count;
`endif
  assign o_req_ready = state == IDLE;
  assign o_slv_valid = state == ISSUE ? sel : '0;
  assign o_slv_addr = addr;
  assign o_slv_wren = wren;
  assign o_slv_wdata = wdata;
  assign o_slv_bmask = bmask;
  assign o_rsp_valid = state == RESP;
  assign o_rsp_rdata = state == RESP ? rdata : '0;
  assign o_rsp_err = state == RESP && err;
  assign o_busy = state != IDLE;
endmodule

// File: tb/tb_lsu_bus_router.sv
// tb_lsu_bus_router: scoreboard bench for lsu_bus_router; expected responses queued at request time
module tb_lsu_bus_router;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready, req_wren, slv_wren, rsp_valid, rsp_err, busy;
  logic [31:0] req_addr, req_wdata, slv_addr, slv_wdata, rsp_rdata;
  logic [3:0] req_bmask, slv_bmask, slv_valid, slv_ready, slv_rvalid;
  logic [127:0] slv_rdata;
`ifdef ROUTER_ERR_CNT_EN
  logic [15:0] err_count;
`endif
  typedef struct packed {logic err; logic [31:0] rdata;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  lsu_bus_router dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_wren(req_wren), .i_req_wdata(req_wdata), .i_req_bmask(req_bmask),
    .o_slv_valid(slv_valid), .o_slv_addr(slv_addr), .o_slv_wren(slv_wren),
    .o_slv_wdata(slv_wdata), .o_slv_bmask(slv_bmask),
    .i_slv_ready(slv_ready), .i_slv_rvalid(slv_rvalid), .i_slv_rdata(slv_rdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err), .o_busy(busy)
`ifdef ROUTER_ERR_CNT_EN
    ,.o_err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    for (int i = 0; i < 20 && !req_ready; i++) step;
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr = a;
    req_wren = w;
    req_wdata = d;
    req_bmask = m;
    step;
    req_valid = 1'b0;
  endtask
  always @(negedge clk)
    if (rsp_valid) begin
      if (sb.size() == 0) chk("spurious_rsp", {rsp_err, rsp_rdata}, 0);
      else chk("rsp", {rsp_err, rsp_rdata}, sb.pop_front());
    end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    {req_valid, req_wren, req_addr, req_wdata, req_bmask} = '0;
    {slv_ready, slv_rvalid, slv_rdata} = '0;
    step;
    chk("rst_outs", {req_ready, slv_valid, rsp_valid, rsp_err, busy}, 8'b1_0000_0_0_0);
    rst = 1'b0;
    step;
    // read from target0, immediate ready, rvalid next cycle
    sb.push_back('{1'b0, 32'hDEAD_BEEF});
    req(32'h0000_0004, 1'b0, 32'h0, 4'hF);
    chk("rd_sel", slv_valid, 4'b0001);
    chk("rd_addr", slv_addr, 32'h0000_0004);
    slv_ready = 4'b0001;
    step;
    slv_ready = '0;
    chk("rd_wait_valid", slv_valid, 0);
    slv_rvalid = 4'b0001;
    slv_rdata[31:0] = 32'hDEAD_BEEF;
    step;
    slv_rvalid = '0;
    chk("rd_lat", rsp_valid, 1);
    // write to target1, ready after two extra cycles
    sb.push_back('{1'b0, 32'h0});
    req(32'h1000_0010, 1'b1, 32'h0000_00A5, 4'h3);
    for (int i = 0; i < 3; i++) begin
      chk("wr_sel", slv_valid, 4'b0010);
      chk("wr_fields", {slv_wren, slv_wdata, slv_bmask}, {1'b1, 32'h0000_00A5, 4'h3});
      if (i == 2) slv_ready = 4'b0010;
      else step;
    end
    step;
    slv_ready = '0;
    chk("wr_rsp", rsp_valid, 1);
    // unmapped read and write
    sb.push_back('{1'b1, 32'h0});
    req(32'h0000_0800, 1'b0, 32'h0, 4'hF);
    chk("unm_rd_lat", {rsp_valid, slv_valid}, 5'b1_0000);
    sb.push_back('{1'b1, 32'h0});
    req(32'h2000_0000, 1'b1, 32'h1234, 4'hF);
    chk("unm_wr_lat", {rsp_valid, slv_valid}, 5'b1_0000);
`ifdef ROUTER_ERR_CNT_EN
    step;
    chk("err_count", err_count, 2);
`endif
    // target2 accepts but never answers; a late rvalid loses to the timeout
    sb.push_back('{1'b1, 32'h0});
    req(32'h1001_0000, 1'b0, 32'h0, 4'hF);
    chk("to_sel", slv_valid, 4'b0100);
    slv_ready = 4'b0100;
    step;
    slv_ready = '0;
    for (int i = 2; i < 15; i++) step;
    chk("to_not_yet", {rsp_valid, busy}, 2'b01);
    slv_rvalid = 4'b0100;
    slv_rdata[95:64] = 32'h1234_5678;
    step;
    slv_rvalid = '0;
    chk("to_rsp", rsp_valid, 1);
    step;
    chk("to_ready", req_ready, 1);
    // read target3; stray rvalid from target0 ignored
    sb.push_back('{1'b0, 32'hCAFE_F00D});
    req(32'h1002_0000, 1'b0, 32'h0, 4'hF);
    chk("t3_sel", slv_valid, 4'b1000);
    slv_ready = 4'b1001;
    step;
    slv_ready = '0;
    slv_rvalid = 4'b0001;
    slv_rdata[31:0] = 32'h0BAD_0BAD;
    step;
    chk("stray_rvalid", {rsp_valid, busy}, 2'b01);
    slv_rvalid = 4'b1001;
    slv_rdata[127:96] = 32'hCAFE_F00D;
    step;
    slv_rvalid = '0;
    chk("t3_rsp", rsp_valid, 1);
    // reset while waiting; late rvalid must not produce a response
    req(32'h0000_0004, 1'b0, 32'h0, 4'hF);
    slv_ready = 4'b0001;
    step;
    slv_ready = '0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_wait", {slv_valid, rsp_valid, req_ready, busy}, 7'b0000_0_1_0);
    slv_rvalid = 4'b0001;
    step;
    slv_rvalid = '0;
    chk("late_rvalid", {rsp_valid, busy}, 2'b00);
    step;
    step;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
